// File: rtl/axis_translate_ctrl_pkg.sv
// Shared encodings for the coordinate-translation sequencer: state codes,
// squarer input selects and register operand selects.
package axis_translate_ctrl_pkg;

   // 4-bit state codes; 12..15 are unused and decode back to IDLE
   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_CLR    = 4'd1;
   localparam logic [3:0] ST_MUL1   = 4'd2;
   localparam logic [3:0] ST_WAIT1  = 4'd3;
   localparam logic [3:0] ST_SQ_T1  = 4'd4;
   localparam logic [3:0] ST_SQ_T2  = 4'd5;
   localparam logic [3:0] ST_MUL2   = 4'd6;
   localparam logic [3:0] ST_WAIT2  = 4'd7;
   localparam logic [3:0] ST_SQ_T1B = 4'd8;
   localparam logic [3:0] ST_SQ_T2B = 4'd9;
   localparam logic [3:0] ST_ADD    = 4'd10;
   localparam logic [3:0] ST_DONE   = 4'b1011;

   // squarer input select (code 3 also routes T1 in the datapath)
   localparam logic [1:0] SQ_T1 = 2'd0;
   localparam logic [1:0] SQ_T2 = 2'd1;
   localparam logic [1:0] SQ_X1 = 2'd2;

   // T1/T2 input select
   localparam logic SEL_EXT = 1'b0;
   localparam logic SEL_SQ  = 1'b1;

endpackage

// File: rtl/axis_translate_ctrl.sv
// Sequencer for X1 = x*z, Z2 = x^2*z^2, X2 = x^4 + z^4 over GF(2^m).
// Moore FSM; only the IDLE operand loads and the WAIT result loads look at
// inputs. All strobes are forced to default while RST_N is low so a reset
// in mid-operation never lets a late load through.
module axis_translate_ctrl
   import axis_translate_ctrl_pkg::*;
(
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       IN_VALID,
   input  logic       MUL_OUT_VALID,
   input  logic       ERROR,
   output logic       MUL_IN_VALID,
   output logic       X1Clear,
   output logic       X1Load,
   output logic       X2Clear,
   output logic       X2Load,
   output logic       Z2Clear,
   output logic       Z2Load,
   output logic       T1Clear,
   output logic       T1Load,
   output logic       T2Clear,
   output logic       T2Load,
   output logic [1:0] squa_sel,
   output logic       T1_sel,
   output logic       T2_sel,
   output logic [3:0] OUT_STATE
);

   logic [3:0] state_q, state_d;
   logic       mul_ok;

   // a multiplier result is accepted only when it is valid and fault-free
   assign mul_ok    = MUL_OUT_VALID && !ERROR;
   assign OUT_STATE = state_q;

   // state register, synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST_N) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // next-state: linear sequence with multiplier retry on ERROR
   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE:   state_d = IN_VALID ? ST_CLR : ST_IDLE;
         ST_CLR:    state_d = ST_MUL1;
         ST_MUL1:   state_d = ST_WAIT1;
         ST_WAIT1:  state_d = !MUL_OUT_VALID ? ST_WAIT1 : (ERROR ? ST_MUL1 : ST_SQ_T1);
         ST_SQ_T1:  state_d = ST_SQ_T2;
         ST_SQ_T2:  state_d = ST_MUL2;
         ST_MUL2:   state_d = ST_WAIT2;
         ST_WAIT2:  state_d = !MUL_OUT_VALID ? ST_WAIT2 : (ERROR ? ST_MUL2 : ST_SQ_T1B);
         ST_SQ_T1B: state_d = ST_SQ_T2B;
         ST_SQ_T2B: state_d = ST_ADD;
         ST_ADD:    state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // output decode; the ADD-state T clears land on the same edge X2 samples T1^T2
   always_comb begin
      MUL_IN_VALID = 1'b0;
      X1Clear      = 1'b0;
      X1Load       = 1'b0;
      X2Clear      = 1'b0;
      X2Load       = 1'b0;
      Z2Clear      = 1'b0;
      Z2Load       = 1'b0;
      T1Clear      = 1'b0;
      T1Load       = 1'b0;
      T2Clear      = 1'b0;
      T2Load       = 1'b0;
      squa_sel     = SQ_T1;
      T1_sel       = SEL_EXT;
      T2_sel       = SEL_EXT;
      if (RST_N) begin
         case (state_q)
            ST_IDLE: begin
               T1Load = IN_VALID;
               T2Load = IN_VALID;
            end
            ST_CLR: begin
               X1Clear = 1'b1;
               X2Clear = 1'b1;
               Z2Clear = 1'b1;
            end
            ST_MUL1, ST_MUL2: MUL_IN_VALID = 1'b1;
            ST_WAIT1:         X1Load = mul_ok;
            ST_WAIT2:         Z2Load = mul_ok;
            ST_SQ_T1, ST_SQ_T1B: begin
               squa_sel = SQ_T1;
               T1_sel   = SEL_SQ;
               T1Load   = 1'b1;
            end
            ST_SQ_T2, ST_SQ_T2B: begin
               squa_sel = SQ_T2;
               T2_sel   = SEL_SQ;
               T2Load   = 1'b1;
            end
            ST_ADD: begin
               X2Load  = 1'b1;
               T1Clear = 1'b1;
               T2Clear = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_translate_ctrl.sv
// Self-checking bench: a hand-written vector table for the named scenarios,
// then a randomized stream whose expected trace is built from the operation
// rules (accept, clear, multiply with retries, two squarings, add, done).
module tb_axis_translate_ctrl;

   logic       CLK = 1'b0;
   logic       RST_N, IN_VALID, MUL_OUT_VALID, ERROR;
   logic       MUL_IN_VALID, X1Clear, X1Load, X2Clear, X2Load, Z2Clear, Z2Load;
   logic       T1Clear, T1Load, T2Clear, T2Load, T1_sel, T2_sel;
   logic [1:0] squa_sel;
   logic [3:0] OUT_STATE;

   always #5 CLK = ~CLK;

   axis_translate_ctrl dut (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .MUL_OUT_VALID(MUL_OUT_VALID),
      .ERROR(ERROR), .MUL_IN_VALID(MUL_IN_VALID), .X1Clear(X1Clear), .X1Load(X1Load),
      .X2Clear(X2Clear), .X2Load(X2Load), .Z2Clear(Z2Clear), .Z2Load(Z2Load),
      .T1Clear(T1Clear), .T1Load(T1Load), .T2Clear(T2Clear), .T2Load(T2Load),
      .squa_sel(squa_sel), .T1_sel(T1_sel), .T2_sel(T2_sel), .OUT_STATE(OUT_STATE)
   );

   // output vector: {MIV,X1C,X1L,X2C,X2L,Z2C,Z2L,T1C,T1L,T2C,T2L,squa_sel[1:0],T1_sel,T2_sel}
   localparam logic [14:0] B_MIV = 15'h4000, B_X1C = 15'h2000, B_X1L = 15'h1000;
   localparam logic [14:0] B_X2C = 15'h0800, B_X2L = 15'h0400, B_Z2C = 15'h0200;
   localparam logic [14:0] B_Z2L = 15'h0100, B_T1C = 15'h0080, B_T1L = 15'h0040;
   localparam logic [14:0] B_T2C = 15'h0020, B_T2L = 15'h0010, B_SQ2 = 15'h0004;
   localparam logic [14:0] B_T1S = 15'h0002, B_T2S = 15'h0001;
   localparam logic [14:0] O_NONE = 15'h0000;
   localparam logic [14:0] O_ACC  = B_T1L | B_T2L;
   localparam logic [14:0] O_CLR  = B_X1C | B_X2C | B_Z2C;
   localparam logic [14:0] O_SQ1  = B_T1S | B_T1L;
   localparam logic [14:0] O_SQ2  = B_SQ2 | B_T2S | B_T2L;
   localparam logic [14:0] O_ADD  = B_X2L | B_T1C | B_T2C;

   typedef struct {
      logic       rst_n, iv, mov, err;
      logic [3:0] st;
      logic [14:0] out;
   } vec_t;

   vec_t tab[$];
   vec_t rnd[$];
   int   n_pass = 0, n_chk = 0;

   function automatic vec_t mk(logic r, logic iv, logic mov, logic err, logic [3:0] st, logic [14:0] out);
      vec_t v;
      v.rst_n = r; v.iv = iv; v.mov = mov; v.err = err; v.st = st; v.out = out;
      return v;
   endfunction

   function automatic logic [14:0] dut_out();
      return {MUL_IN_VALID, X1Clear, X1Load, X2Clear, X2Load, Z2Clear, Z2Load,
              T1Clear, T1Load, T2Clear, T2Load, squa_sel, T1_sel, T2_sel};
   endfunction

   // drive one cycle, compare mid-cycle, advance past the next edge
   task automatic apply(input vec_t v, input string tag, input int idx);
      logic [14:0] o;
      RST_N = v.rst_n; IN_VALID = v.iv; MUL_OUT_VALID = v.mov; ERROR = v.err;
      @(negedge CLK);
      n_chk++;
      if (OUT_STATE === v.st) n_pass++;
      else $display("FAIL %s[%0d] state: got %0d expected %0d", tag, idx, OUT_STATE, v.st);
      o = dut_out();
      n_chk++;
      if (o === v.out) n_pass++;
      else $display("FAIL %s[%0d] strobes: got %h expected %h (state %0d)", tag, idx, o, v.out, v.st);
      @(posedge CLK); #1;
   endtask

   // expected trace for one randomized operation, built from the operation rules
   task automatic gen_op();
      int gap, w;
      bit e;
      gap = $urandom_range(0, 3);
      for (int i = 0; i < gap; i++)
         rnd.push_back(mk(1, 0, 1'($urandom), 1'($urandom), 4'd0, O_NONE));
      rnd.push_back(mk(1, 1, 1'($urandom), 1'($urandom), 4'd0, O_ACC));
      rnd.push_back(mk(1, 1'($urandom), 1'($urandom), 1'($urandom), 4'd1, O_CLR));
      for (int k = 0; k < 2; k++) begin
         logic [3:0] mst, wst;
         mst = (k == 0) ? 4'd2 : 4'd6;
         wst = mst + 4'd1;
         do begin
            rnd.push_back(mk(1, 1'($urandom), 1'($urandom), 1'($urandom), mst, B_MIV));
            w = $urandom_range(0, 3);
            for (int i = 0; i < w; i++)
               rnd.push_back(mk(1, 1'($urandom), 0, 1'($urandom), wst, O_NONE));
            e = ($urandom_range(0, 3) == 0);
            rnd.push_back(mk(1, 1'($urandom), 1, e, wst,
                             e ? O_NONE : ((k == 0) ? B_X1L : B_Z2L)));
         end while (e);
         rnd.push_back(mk(1, 1'($urandom), 1'($urandom), 1'($urandom), mst + 4'd2, O_SQ1));
         rnd.push_back(mk(1, 1'($urandom), 1'($urandom), 1'($urandom), mst + 4'd3, O_SQ2));
      end
      rnd.push_back(mk(1, 1'($urandom), 1'($urandom), 1'($urandom), 4'd10, O_ADD));
      // IN_VALID in DONE must not shortcut the IDLE visit
      rnd.push_back(mk(1, 1'($urandom), 1'($urandom), 1'($urandom), 4'd11, O_NONE));
   endtask

   initial begin
      // reset held two cycles with IN_VALID high, then a nominal run (mult latency 3)
      tab.push_back(mk(0, 1, 0, 0, 4'd0, O_NONE));
      tab.push_back(mk(0, 1, 0, 0, 4'd0, O_NONE));
      tab.push_back(mk(1, 1, 0, 0, 4'd0, O_ACC));
      tab.push_back(mk(1, 0, 0, 0, 4'd1, O_CLR));
      tab.push_back(mk(1, 0, 0, 0, 4'd2, B_MIV));
      tab.push_back(mk(1, 0, 0, 0, 4'd3, O_NONE));
      tab.push_back(mk(1, 0, 0, 0, 4'd3, O_NONE));
      tab.push_back(mk(1, 0, 1, 0, 4'd3, B_X1L));
      tab.push_back(mk(1, 0, 0, 0, 4'd4, O_SQ1));
      tab.push_back(mk(1, 0, 0, 0, 4'd5, O_SQ2));
      tab.push_back(mk(1, 0, 0, 0, 4'd6, B_MIV));
      tab.push_back(mk(1, 0, 0, 0, 4'd7, O_NONE));
      tab.push_back(mk(1, 0, 0, 0, 4'd7, O_NONE));
      tab.push_back(mk(1, 0, 1, 0, 4'd7, B_Z2L));
      tab.push_back(mk(1, 0, 0, 0, 4'd8, O_SQ1));
      tab.push_back(mk(1, 0, 0, 0, 4'd9, O_SQ2));
      tab.push_back(mk(1, 0, 0, 0, 4'd10, O_ADD));
      tab.push_back(mk(1, 0, 0, 0, 4'd11, O_NONE));
      tab.push_back(mk(1, 0, 0, 0, 4'd0, O_NONE));
      // IN_VALID held high; faults in both WAIT states; re-accept right after DONE
      tab.push_back(mk(1, 1, 0, 0, 4'd0, O_ACC));
      tab.push_back(mk(1, 1, 0, 0, 4'd1, O_CLR));
      tab.push_back(mk(1, 1, 0, 0, 4'd2, B_MIV));
      tab.push_back(mk(1, 1, 1, 1, 4'd3, O_NONE));
      tab.push_back(mk(1, 1, 0, 0, 4'd2, B_MIV));
      tab.push_back(mk(1, 1, 1, 0, 4'd3, B_X1L));
      tab.push_back(mk(1, 1, 0, 0, 4'd4, O_SQ1));
      tab.push_back(mk(1, 1, 0, 0, 4'd5, O_SQ2));
      tab.push_back(mk(1, 1, 0, 0, 4'd6, B_MIV));
      tab.push_back(mk(1, 1, 1, 1, 4'd7, O_NONE));
      tab.push_back(mk(1, 1, 0, 0, 4'd6, B_MIV));
      tab.push_back(mk(1, 1, 1, 0, 4'd7, B_Z2L));
      tab.push_back(mk(1, 1, 0, 0, 4'd8, O_SQ1));
      tab.push_back(mk(1, 1, 0, 0, 4'd9, O_SQ2));
      tab.push_back(mk(1, 1, 0, 0, 4'd10, O_ADD));
      tab.push_back(mk(1, 1, 0, 0, 4'd11, O_NONE));
      tab.push_back(mk(1, 1, 0, 0, 4'd0, O_ACC));
      // reset arriving in WAIT2 together with a good result: no Z2Load
      tab.push_back(mk(1, 0, 0, 0, 4'd1, O_CLR));
      tab.push_back(mk(1, 0, 0, 0, 4'd2, B_MIV));
      tab.push_back(mk(1, 0, 1, 0, 4'd3, B_X1L));
      tab.push_back(mk(1, 0, 0, 0, 4'd4, O_SQ1));
      tab.push_back(mk(1, 0, 0, 0, 4'd5, O_SQ2));
      tab.push_back(mk(1, 0, 0, 0, 4'd6, B_MIV));
      tab.push_back(mk(0, 0, 1, 0, 4'd7, O_NONE));
      tab.push_back(mk(1, 0, 1, 0, 4'd0, O_NONE));

      for (int i = 0; i < 40; i++) gen_op();
      rnd.push_back(mk(1, 0, 0, 0, 4'd0, O_NONE));

      // one reset edge so the table starts from a known state
      RST_N = 1'b0; IN_VALID = 1'b0; MUL_OUT_VALID = 1'b0; ERROR = 1'b0;
      @(posedge CLK); #1;
      for (int i = 0; i < tab.size(); i++) apply(tab[i], "tab", i);
      for (int i = 0; i < rnd.size(); i++) apply(rnd[i], "rnd", i);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // safety net: never let the run hang
   initial begin
      #2000000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule
